writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/pack.sv | 14 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/writeback_arbiter.sv | 111 +++++++++++
 tb/tb_writeback_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack.sv
// Shared writeback payload type and default sizing constants for the writeback arbiter.
package pack;
  localparam int unsigned NUM_CH_DEF = 3;
  localparam int unsigned DEPTH_DEF  = 2;
  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW     = 5;

  typedef struct packed {
    logic [REG_AW-1:0]   destinationRegister;
    logic [XLEN_DEF-1:0] data;
    logic                writebackEnable;
    logic                illegal;
  } wbPayload;
endpackage

// File: rtl/wb_fifo.sv
// Per-channel result queue; exposes every slot plus its occupancy so the
// top can track registers with pending writes.
module wb_fifo
  import pack::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  wbPayload             din,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output wbPayload             head,
  output wbPayload [DEPTH-1:0] contents,
  output logic [DEPTH-1:0]     occupied
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DEPTH-1:0]     valid_q;
  wbPayload [DEPTH-1:0] mem;
  logic                 do_push;
  logic                 do_pop;

  // A slot-valid bit per entry: write slot taken means full, read slot free means empty.
  assign full     = valid_q[wr_ptr];
  assign empty    = !valid_q[rd_ptr];
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign head     = mem[rd_ptr];
  assign contents = mem;
  assign occupied = valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr          <= wr_ptr + AW'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr          <= rd_ptr + AW'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
    end
  end

  // Payload storage; slots are only observed while their valid bit is set.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: per-channel result queues drained one entry
// per cycle into the register file, with trap, pending-write and retire tracking.
module writeback_arbiter
  import pack::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned XLEN   = XLEN_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [NUM_CH-1:0]     chValid,
  input  wbPayload [NUM_CH-1:0] chPayload,
  output logic [NUM_CH-1:0]     chReady,
  output logic                  destinationEnable,
  output logic [4:0]            writeAddress,
  output logic [XLEN-1:0]       writeData,
  output logic                  trapValid,
  output logic [31:0]           pendingMask,
  output logic [63:0]           retireCount
);
  localparam int unsigned PW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]                full;
  logic [NUM_CH-1:0]                empty;
  logic [NUM_CH-1:0]                pop;
  wbPayload [NUM_CH-1:0]            head;
  wbPayload [NUM_CH-1:0][DEPTH-1:0] contents;
  logic [NUM_CH-1:0][DEPTH-1:0]     occupied;
  logic [PW-1:0]                    rr_ptr;
  logic [PW-1:0]                    grant_idx;
  logic [PW-1:0]                    scan_idx;
  logic                             grant_valid;
  wbPayload                         grant_head;

  // Ready is withheld during reset and flush so nothing is enqueued then.
  assign chReady = ~full & {NUM_CH{!flush && reset}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .push     (chValid[i] && chReady[i]),
      .din      (chPayload[i]),
      .pop      (pop[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .head     (head[i]),
      .contents (contents[i]),
      .occupied (occupied[i])
    );
  end

  // First non-empty channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scan_idx = PW'((32'(rr_ptr) + k) % NUM_CH);
      if (!grant_valid && !empty[scan_idx] && !flush) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
    end
  end

  assign grant_head   = head[grant_idx];
  assign writeAddress = grant_valid ? grant_head.destinationRegister : '0;
  assign writeData    = grant_valid ? XLEN'(grant_head.data) : '0;
  assign trapValid    = grant_valid && grant_head.illegal;
  assign destinationEnable = grant_valid && grant_head.writebackEnable &&
                             !grant_head.illegal &&
                             (grant_head.destinationRegister != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      retireCount <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == PW'(NUM_CH - 1)) ? '0 : grant_idx + PW'(1);
      if (!grant_head.illegal) begin
        retireCount <= retireCount + 64'd1;
      end
    end
  end

  // Any occupied slot holding a legal enabled write marks its register; x0 never pends.
  always_comb begin
    pendingMask = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        if (occupied[c][s] && contents[c][s].writebackEnable && !contents[c][s].illegal) begin
          pendingMask[contents[c][s].destinationRegister] = 1'b1;
        end
      end
    end
    pendingMask[0] = 1'b0;
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter: a queue-level reference
// model predicts results; a separate monitor checks every write/trap strobe.
`timescale 1ns/1ps
module tb_writeback_arbiter;
  import pack::*;

  localparam int unsigned NC = 3;
  localparam int unsigned DP = 2;
  localparam int unsigned XL = 32;

  logic              clock;
  logic              reset;
  logic              flush;
  logic [NC-1:0]     chValid;
  wbPayload [NC-1:0] chPayload;
  logic [NC-1:0]     chReady;
  logic              destinationEnable;
  logic [4:0]        writeAddress;
  logic [XL-1:0]     writeData;
  logic              trapValid;
  logic [31:0]       pendingMask;
  logic [63:0]       retireCount;

  writeback_arbiter #(.NUM_CH(NC), .DEPTH(DP), .XLEN(XL)) dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .chValid           (chValid),
    .chPayload         (chPayload),
    .chReady           (chReady),
    .destinationEnable (destinationEnable),
    .writeAddress      (writeAddress),
    .writeData         (writeData),
    .trapValid         (trapValid),
    .pendingMask       (pendingMask),
    .retireCount       (retireCount)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state: one queue per channel, round-robin start, retire count.
  wbPayload    mq[NC][$];
  int unsigned m_rr;
  logic [63:0] m_retire;
  logic [NC-1:0] m_ready;
  bit          m_grant;
  int unsigned m_gidx;
  logic [38:0] exp_q[$];
  logic [38:0] mon_ev;
  wbPayload [NC-1:0] stim_p;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic wbPayload mk(input logic [4:0] rd, input logic [31:0] d,
                                  input logic we, input logic il);
    wbPayload p;
    p.destinationRegister = rd;
    p.data = d;
    p.writebackEnable = we;
    p.illegal = il;
    return p;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) mq[c].delete();
    m_rr = 0;
  endtask

  // Predict this cycle's visible outputs from the model queues and check them.
  task automatic model_eval();
    logic [31:0] pm;
    wbPayload h;
    logic de;
    logic tr;
    pm = '0;
    for (int c = 0; c < NC; c++) begin
      m_ready[c] = (mq[c].size() < DP) && !flush;
      for (int j = 0; j < mq[c].size(); j++) begin
        h = mq[c][j];
        if (h.writebackEnable && !h.illegal && h.destinationRegister != 5'd0)
          pm[h.destinationRegister] = 1'b1;
      end
    end
    m_grant = 1'b0;
    m_gidx = 0;
    if (!flush) begin
      for (int k = 0; k < NC; k++) begin
        int unsigned c;
        c = (m_rr + 32'(k)) % NC;
        if (!m_grant && mq[c].size() > 0) begin
          m_grant = 1'b1;
          m_gidx = c;
        end
      end
    end
    chk("chReady", 64'(chReady), 64'(m_ready));
    chk("pendingMask", 64'(pendingMask), 64'(pm));
    chk("retireCount", retireCount, m_retire);
    if (m_grant) begin
      h = mq[m_gidx][0];
      de = h.writebackEnable && !h.illegal && (h.destinationRegister != 5'd0);
      tr = h.illegal;
      if (de || tr) exp_q.push_back({de, tr, h.destinationRegister, h.data});
    end else begin
      chk("idle_writeAddress", 64'(writeAddress), 64'd0);
      chk("idle_writeData", 64'(writeData), 64'd0);
    end
  endtask

  task automatic model_commit();
    wbPayload h;
    if (flush) begin
      model_clear();
    end else begin
      if (m_grant) begin
        h = mq[m_gidx].pop_front();
        if (!h.illegal) m_retire = m_retire + 64'd1;
        m_rr = (m_gidx + 1) % NC;
      end
      for (int c = 0; c < NC; c++)
        if (chValid[c] && m_ready[c]) mq[c].push_back(chPayload[c]);
    end
  endtask

  task automatic drive_eval(input logic [NC-1:0] v, input wbPayload [NC-1:0] p, input logic f);
    @(negedge clock);
    chValid = v;
    chPayload = p;
    flush = f;
    #1;
    model_eval();
  endtask

  task automatic commit();
    @(posedge clock);
    model_commit();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_eval('0, '0, 1'b0);
      commit();
    end
  endtask

  task automatic randomize_payload();
    for (int c = 0; c < NC; c++)
      stim_p[c] = mk(5'($urandom_range(0, 12)), $urandom, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 7) == 0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      randomize_payload();
      drive_eval(NC'($urandom), stim_p, $urandom_range(0, 39) == 0);
      commit();
    end
  endtask

  // Monitor: every strobe the DUT presents must match the next predicted event.
  always @(negedge clock) begin
    #3;
    if (destinationEnable || trapValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe got de=%0b trap=%0b addr=%0d data=%0h expected none",
                 destinationEnable, trapValid, writeAddress, writeData);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("writeback_event", 64'({destinationEnable, trapValid, writeAddress, writeData}),
            64'(mon_ev));
      end
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    chValid = '0;
    chPayload = '0;
    m_retire = '0;
    model_clear();
    #1;
    chk("reset_chReady", 64'(chReady), 64'd0);
    chk("reset_destinationEnable", 64'(destinationEnable), 64'd0);
    chk("reset_writeAddress", 64'(writeAddress), 64'd0);
    chk("reset_pendingMask", 64'(pendingMask), 64'd0);
    chk("reset_retireCount", retireCount, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("post_reset_chReady", 64'(chReady), 64'h7);

    // Single legal write with one-cycle latency.
    stim_p = '0;
    stim_p[0] = mk(5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    drive_eval(3'b001, stim_p, 1'b0);
    commit();
    drive_eval('0, '0, 1'b0);
    chk("single_de", 64'(destinationEnable), 64'd1);
    chk("single_addr", 64'(writeAddress), 64'd5);
    chk("single_data", 64'(writeData), 64'hDEADBEEF);
    commit();
    #1;
    chk("single_retire", retireCount, 64'd1);

    // Flush clears rr to 0, then all channels push every cycle.
    drive_eval('0, '0, 1'b1);
    commit();
    for (int cyc = 0; cyc < 6; cyc++) begin
      for (int c = 0; c < NC; c++)
        stim_p[c] = mk(5'(c + 1), 32'(c * 16 + cyc), 1'b1, 1'b0);
      drive_eval('1, stim_p, 1'b0);
      if (cyc >= 1) chk("rr_order", 64'(writeAddress), 64'((cyc - 1) % 3 + 1));
      if (cyc == 2) chk("rr_ready_drop", 64'(chReady), 64'h1);
      commit();
    end
    idle(8);

    // x0 write retires silently; illegal entry traps without retiring.
    stim_p = '0;
    stim_p[0] = mk(5'd0, 32'h1111, 1'b1, 1'b0);
    drive_eval(3'b001, stim_p, 1'b0);
    commit();
    stim_p[0] = mk(5'd7, 32'h2222, 1'b1, 1'b1);
    drive_eval(3'b001, stim_p, 1'b0);
    chk("x0_no_write", 64'({destinationEnable, trapValid}), 64'd0);
    commit();
    drive_eval('0, '0, 1'b0);
    chk("illegal_trap", 64'({destinationEnable, trapValid}), 64'd1);
    commit();

    // Pending mask tracks only the enabled write to x9.
    idle(2);
    stim_p = '0;
    stim_p[1] = mk(5'd9, 32'h9, 1'b1, 1'b0);
    stim_p[2] = mk(5'd9, 32'h99, 1'b0, 1'b0);
    drive_eval(3'b110, stim_p, 1'b0);
    commit();
    #1;
    chk("pending_x9", 64'(pendingMask), 64'h200);
    idle(3);
    #1;
    chk("pending_cleared", 64'(pendingMask), 64'd0);

    // Fill every queue, then flush.
    for (int i = 0; i < 4; i++) begin
      randomize_payload();
      drive_eval('1, stim_p, 1'b0);
      commit();
    end
    randomize_payload();
    drive_eval('1, stim_p, 1'b1);
    chk("flush_no_strobe", 64'({destinationEnable, trapValid}), 64'd0);
    chk("flush_ready", 64'(chReady), 64'd0);
    commit();
    #1;
    chk("flush_pending", 64'(pendingMask), 64'd0);

    rand_cycles(400);

    // retireCount wraps to zero.
    idle(8);
    #2;
    force dut.retireCount = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retireCount;
    m_retire = 64'hFFFF_FFFF_FFFF_FFFF;
    stim_p = '0;
    stim_p[0] = mk(5'd3, 32'h33, 1'b1, 1'b0);
    drive_eval(3'b001, stim_p, 1'b0);
    commit();
    drive_eval('0, '0, 1'b0);
    commit();
    #1;
    chk("retire_wrap", retireCount, 64'd0);

    // Asynchronous reset in the middle of a burst.
    rand_cycles(10);
    randomize_payload();
    drive_eval('1, stim_p, 1'b0);
    #4;
    reset = 1'b0;
    #1;
    chk("midreset_de", 64'(destinationEnable), 64'd0);
    chk("midreset_trap", 64'(trapValid), 64'd0);
    chk("midreset_addr", 64'(writeAddress), 64'd0);
    chk("midreset_data", 64'(writeData), 64'd0);
    chk("midreset_ready", 64'(chReady), 64'd0);
    chk("midreset_pending", 64'(pendingMask), 64'd0);
    chk("midreset_retire", retireCount, 64'd0);
    model_clear();
    m_retire = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    chValid = '0;
    flush = 1'b0;

    rand_cycles(200);
    idle(10);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
